// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
//
// Plays back a packed score held in a synchronous ROM. Each ROM entry is
// {note[3:0], octave[3:0], duration[7:0]}. A note is held for duration beat
// units of TICK_DIV clock cycles each. A duration of zero marks the end of
// the score. This block is the only driver of the pitch_generator
// note/octave inputs.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   start     single-cycle pulse, begins playback at address 0 when idle/done
//   stop      level, aborts playback and returns to idle (highest priority)
//   pause     level, freezes note timing while high during playback
//   loop      level, sampled at the end marker; high restarts from address 0
//   rom_addr  score ROM address
//   rom_data  score ROM entry, valid one cycle after rom_addr
//   note      note value to pitch_generator
//   octave    octave value to pitch_generator
//   gate      high while the tone should be audible
//   busy      high while fetching or playing
//   done      one-cycle pulse when the score ends without looping
// ---------------------------------------------------------------------------
module melody_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 12500000,
    parameter int GAP      = 1250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [3:0]        note,
    output logic [3:0]        octave,
    output logic              gate,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_CNT = DIV_W'(GAP);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        PLAY,
        DONE
    } state_t;

    state_t            state;
    logic [7:0]        beat_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              rest;

    logic [3:0]        rom_note;
    logic [3:0]        rom_octave;
    logic [7:0]        rom_dur;
    logic [DIV_W-1:0]  div_dec;

    // Field split of the ROM word and the next value of the beat divider,
    // pulled out so the state machine below reads in score terms.
    assign rom_note   = rom_data[15:12];
    assign rom_octave = rom_data[11:8];
    assign rom_dur    = rom_data[7:0];
    assign div_dec    = div_cnt - DIV_W'(1);

    // Sequencer state machine. All outputs are registered, so gate is
    // computed from the counter values the next cycle will hold: it drops
    // when those values fall inside the final GAP cycles of the entry, on
    // rests, and for every cycle in which a pause froze the counters.
    // Because GAP is smaller than TICK_DIV, a freshly loaded beat (divider
    // at TICK_DIV-1) can never be inside the gap, so only the rest flag
    // matters on a load or a beat rollover.
    // stop is checked first so it wins over start, pause and end-of-note.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            note     <= '0;
            octave   <= '0;
            gate     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            beat_cnt <= '0;
            div_cnt  <= '0;
            rest     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                rom_addr <= '0;
                gate     <= 1'b0;
                busy     <= 1'b0;
                beat_cnt <= '0;
                div_cnt  <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        gate <= 1'b0;
                        if (start) begin
                            rom_addr <= '0;
                            busy     <= 1'b1;
                            state    <= READ;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    READ: begin
                        gate  <= 1'b0;
                        state <= LATCH;
                    end
                    LATCH: begin
                        if (rom_dur == 8'd0) begin
                            gate <= 1'b0;
                            if (loop) begin
                                rom_addr <= '0;
                                state    <= READ;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end
                        end else begin
                            note     <= rom_note;
                            octave   <= rom_octave;
                            rest     <= (rom_note >= 4'd12);
                            beat_cnt <= rom_dur;
                            div_cnt  <= DIV_TOP;
                            gate     <= (rom_note < 4'd12);
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (pause) begin
                            gate <= 1'b0;
                        end else if (div_cnt == '0) begin
                            if (beat_cnt == 8'd1) begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                gate     <= 1'b0;
                                state    <= READ;
                            end else begin
                                beat_cnt <= beat_cnt - 8'd1;
                                div_cnt  <= DIV_TOP;
                                gate     <= !rest;
                            end
                        end else begin
                            div_cnt <= div_dec;
                            gate    <= !rest &&
                                       !((beat_cnt == 8'd1) && (div_dec < GAP_CNT));
                        end
                    end
                    default: begin
                        gate  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// ---------------------------------------------------------------------------
// tb_melody_sequencer
//
// Drives melody_sequencer with directed score scenarios and randomized
// start/stop/pause/loop activity over random scores. A behavioural model
// tracks playback as "cycles elapsed within the current entry" and predicts
// every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_melody_sequencer;

    localparam int ADDR_W = 2;
    localparam int TICK   = 4;
    localparam int GAP    = 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [3:0]        note;
    logic [3:0]        octave;
    logic              gate;
    logic              busy;
    logic              done;

    logic [15:0]       rom [4];

    int checks;
    int errors;
    int done_count;
    bit saw_wrap;
    logic [ADDR_W-1:0] prev_addr;

    bit          m_active;
    int          m_pos;
    int          m_len;
    bit          m_rest;
    bit          m_held;
    bit          m_done;
    logic [3:0]  m_note;
    logic [3:0]  m_oct;
    logic [ADDR_W-1:0] m_addr;

    melody_sequencer #(
        .ADDR_W   (ADDR_W),
        .TICK_DIV (TICK),
        .GAP      (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .loop     (loop),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note     (note),
        .octave   (octave),
        .gate     (gate),
        .busy     (busy),
        .done     (done)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Score ROM with one cycle of synchronous read latency.
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Model reset: nothing playing, all outputs at zero.
    task automatic modelReset();
        m_active = 1'b0;
        m_pos    = 0;
        m_len    = 0;
        m_rest   = 1'b0;
        m_held   = 1'b0;
        m_done   = 1'b0;
        m_note   = '0;
        m_oct    = '0;
        m_addr   = '0;
    endtask

    // Behavioural model of one clock edge. Within an entry, position 0 is
    // the ROM read cycle, position 1 the latch cycle and positions
    // 2 .. len+1 the len = duration*TICK playing cycles. A pause while
    // playing repeats the current position and marks that cycle silent.
    task automatic modelStep();
        logic [15:0] entry;
        m_done = 1'b0;
        if (stop) begin
            m_active = 1'b0;
            m_addr   = '0;
            m_held   = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_addr   = '0;
                m_held   = 1'b0;
            end
        end else if (m_pos == 0) begin
            m_pos = 1;
        end else if (m_pos == 1) begin
            entry = rom[m_addr];
            if (entry[7:0] == 8'd0) begin
                if (loop) begin
                    m_addr = '0;
                    m_pos  = 0;
                end else begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else begin
                m_note = entry[15:12];
                m_oct  = entry[11:8];
                m_rest = (entry[15:12] >= 4'd12);
                m_len  = int'(entry[7:0]) * TICK;
                m_pos  = 2;
            end
        end else if (pause) begin
            m_held = 1'b1;
        end else begin
            m_held = 1'b0;
            if (m_pos == m_len + 1) begin
                m_addr = m_addr + 1'b1;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    // Tone is audible while playing a non-rest entry outside the final GAP
    // cycles, except in cycles repeated because of a pause.
    function automatic logic expGate();
        return m_active && (m_pos >= 2) && !m_rest && !m_held &&
               ((m_pos - 2) < (m_len - GAP));
    endfunction

    // Compare every DUT output with the model.
    task automatic compareAll();
        checkOutput("note",     32'(note),     32'(m_note));
        checkOutput("octave",   32'(octave),   32'(m_oct));
        checkOutput("gate",     32'(gate),     32'(expGate()));
        checkOutput("busy",     32'(busy),     32'(m_active));
        checkOutput("done",     32'(done),     32'(m_done));
        checkOutput("rom_addr", 32'(rom_addr), 32'(m_addr));
    endtask

    // One clock cycle: drive inputs on the falling edge, advance the model
    // on the rising edge, compare just after it. Also tracks done pulses
    // and address wrap-around for the scenario-level checks.
    task automatic applyStimulus(input logic s, input logic st,
                                 input logic p, input logic l);
        @(negedge clk);
        start = s;
        stop  = st;
        pause = p;
        loop  = l;
        prev_addr = rom_addr;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        if (done) done_count++;
        if (busy && prev_addr == 2'd3 && rom_addr == 2'd0) saw_wrap = 1'b1;
    endtask

    // Idle cycles with all controls low except loop.
    task automatic runCycles(input int n, input logic l);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, l);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic resetAsync();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        loop  = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed score scenarios followed by randomized episodes.
    initial begin
        checks     = 0;
        errors     = 0;
        done_count = 0;
        saw_wrap   = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        loop       = 1'b0;
        for (int i = 0; i < 4; i++) rom[i] = 16'h0000;
        modelReset();
        #2;
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Single note then end marker: done pulses exactly once.
        rom[0] = 16'h9702; rom[1] = 16'h0000;
        done_count = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(16, 1'b0);
        checkOutput("done_once", 32'(done_count), 32'd1);

        // Note followed by a rest entry.
        rom[0] = 16'h4503; rom[1] = 16'hF001; rom[2] = 16'h0000;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(24, 1'b0);

        // Looping score never asserts done.
        rom[0] = 16'h1402; rom[1] = 16'h0000;
        done_count = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        runCycles(50, 1'b1);
        checkOutput("loop_no_done", 32'(done_count), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        runCycles(3, 1'b0);

        // Ten-cycle pause in the middle of a note.
        rom[0] = 16'h3105; rom[1] = 16'h0000;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(6, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runCycles(24, 1'b0);

        // Stop on the final playing cycle of a note, with start also high.
        rom[0] = 16'h5502; rom[1] = 16'h6602;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(9, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        runCycles(5, 1'b0);

        // Reset mid-note, then a full score that wraps the address 3 -> 0.
        rom[0] = 16'h1101; rom[1] = 16'h2201; rom[2] = 16'h3301; rom[3] = 16'h4401;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(4, 1'b0);
        resetAsync();
        saw_wrap = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(30, 1'b0);
        checkOutput("addr_wrap", 32'(saw_wrap), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        // Longest duration.
        rom[0] = 16'h2AFF; rom[1] = 16'h0000;
        done_count = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(255 * TICK + 4, 1'b0);
        checkOutput("long_done", 32'(done_count), 32'd1);

        // Random scores with random control activity.
        for (int ep = 0; ep < 40; ep++) begin
            logic lp;
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                rom[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0) ? 8'd0
                                                      : 8'($urandom_range(1, 3))};
            end
            lp = 1'($urandom_range(0, 1));
            applyStimulus(1'b1, 1'b0, 1'b0, lp);
            for (int c = 0; c < 60; c++) begin
                applyStimulus($urandom_range(0, 19) == 0,
                              $urandom_range(0, 59) == 0,
                              $urandom_range(0, 7) == 0,
                              lp);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
